// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  // Width of the latched request address field.
  localparam int DMEM_AW = 9;

  // RISC-V funct3 access-size/sign codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Request kind encoded as {req_rd, req_wr}.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_STORE = 2'b01,
    OP_LOAD  = 2'b10,
    OP_BOTH  = 2'b11
  } dmem_op_e;

  typedef struct packed {
    dmem_op_e           op;
    logic [DMEM_AW-1:0] addr;
    logic [31:0]        wdata;
    logic [2:0]         funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for sub-word RISC-V loads and stores:
// byte enables, replicated write data, extended load data and a
// misalignment / illegal-encoding flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_data,
  output logic        bad
);

  logic [31:0] shifted;

  // Decode access size, pick lanes and extend the selected load bytes.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'd0;
    load_data  = 32'd0;
    bad        = 1'b0;
    shifted    = rword >> {addr_lo, 3'b000};
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        bad        = addr_lo[0];
        byte_en    = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        load_data  = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        bad        = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        load_data  = rword;
      end
      F3_BU: begin
        bad       = is_store;
        load_data = {24'd0, shifted[7:0]};
      end
      F3_HU: begin
        bad       = is_store | addr_lo[0];
        load_data = {16'd0, shifted[15:0]};
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, holds the pipeline for
// WAIT_CYCLES+1 cycles, then performs the access on the edge into DONE.
// Optional performance counters are built when DMEM_PERF_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = DMEM_AW,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_rd,
  input  logic                  req_wr,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  err,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_stalls
);

  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        latch;
  logic        exec;
  dmem_req_t   req_q;

  dmem_op_e              exec_op;
  logic [DM_ADDRESS-1:0] exec_addr;
  logic [31:0]           exec_wdata;
  logic [2:0]            exec_f3;

  logic [31:0] mem [0:WORDS-1];
  logic [DM_ADDRESS-3:0] word_idx;
  logic [31:0] rword;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] load_data;
  logic        lane_bad;
  logic        bad_req;
  logic        do_load;
  logic        do_store;

  // With zero wait states the access runs on the accept edge, so the live
  // request is used in IDLE and the latched copy everywhere else.
  always_comb begin
    if (state_q == IDLE) begin
      exec_op    = dmem_op_e'({req_rd, req_wr});
      exec_addr  = req_addr;
      exec_wdata = req_wdata;
      exec_f3    = req_funct3;
    end else begin
      exec_op    = req_q.op;
      exec_addr  = DM_ADDRESS'(req_q.addr);
      exec_wdata = req_q.wdata;
      exec_f3    = req_q.funct3;
    end
  end

  assign word_idx = exec_addr[DM_ADDRESS-1:2];
  assign rword    = mem[word_idx];

  dmem_lane_align u_align (
    .funct3     (exec_f3),
    .addr_lo    (exec_addr[1:0]),
    .is_store   (exec_op == OP_STORE),
    .wdata      (exec_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .load_data  (load_data),
    .bad        (lane_bad)
  );

  assign bad_req  = lane_bad | (exec_op == OP_BOTH);
  assign do_load  = exec & ~bad_req & (exec_op == OP_LOAD);
  assign do_store = exec & ~bad_req & (exec_op == OP_STORE);

  // Next-state, wait counter and stall; stall in IDLE follows the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    latch   = 1'b0;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rd | req_wr) begin
          stall = 1'b1;
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = DONE;
            exec    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          exec    = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on acceptance; it is not reset because it is only
  // consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (latch) begin
      req_q.op     <= dmem_op_e'({req_rd, req_wr});
      req_q.addr   <= DMEM_AW'(req_addr);
      req_q.wdata  <= req_wdata;
      req_q.funct3 <= req_funct3;
    end
  end

  // Load result and one-cycle completion/error pulses, visible in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      if (exec && bad_req) begin
        err     <= 1'b1;
        rd_data <= '0;
      end else if (do_load) begin
        rd_valid <= 1'b1;
        rd_data  <= DATA_W'(load_data);
      end
    end
  end

  // Byte-enabled store; reset suppresses it so an aborted access never lands.
  always_ff @(posedge clk) begin
    if (!reset && do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

`ifdef DMEM_PERF_EN
  logic [31:0] loads_q, stores_q, stalls_q;

  // Free-running wrap-around counters of completed accesses and stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      stalls_q <= 32'd0;
    end else begin
      if (do_load)  loads_q  <= loads_q + 32'd1;
      if (do_store) stores_q <= stores_q + 32'd1;
      if (stall)    stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_loads  = 32'd0;
  assign perf_stores = 32'd0;
  assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0 and 1) driven
// by directed steps; expected completions go through a scoreboard queue.
module tb_dmem_responder;

  logic        clk;
  logic        reset    [3];
  logic        req_rd   [3];
  logic        req_wr   [3];
  logic [8:0]  req_addr [3];
  logic [31:0] req_wdata[3];
  logic [2:0]  req_f3   [3];
  logic        stall    [3];
  logic [31:0] rd_data  [3];
  logic        rd_valid [3];
  logic        err      [3];
  logic [31:0] perf_loads [3];
  logic [31:0] perf_stores[3];
  logic [31:0] perf_stalls[3];

  int waits[3] = '{2, 0, 1};
  logic [31:0] last_rd[3] = '{32'd0, 32'd0, 32'd0};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic        err;
    logic [31:0] data;
    int          stalls;
    string       tag;
  } exp_t;

  exp_t sb[$];

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset[0]), .req_rd(req_rd[0]), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_f3[0]),
    .stall(stall[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .err(err[0]),
    .perf_loads(perf_loads[0]), .perf_stores(perf_stores[0]), .perf_stalls(perf_stalls[0])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset[1]), .req_rd(req_rd[1]), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_f3[1]),
    .stall(stall[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .err(err[1]),
    .perf_loads(perf_loads[1]), .perf_stores(perf_stores[1]), .perf_stalls(perf_stalls[1])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset[2]), .req_rd(req_rd[2]), .req_wr(req_wr[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_funct3(req_f3[2]),
    .stall(stall[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .err(err[2]),
    .perf_loads(perf_loads[2]), .perf_stores(perf_stores[2]), .perf_stalls(perf_stalls[2])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case the directed sequence wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clearReq(input int d);
    req_rd[d]    = 1'b0;
    req_wr[d]    = 1'b0;
    req_addr[d]  = 9'd0;
    req_wdata[d] = 32'd0;
    req_f3[d]    = 3'd0;
  endtask

  // Pops the next expected completion and compares it with the DONE cycle.
  task automatic checkOutput(input int d, input int n, input bit done);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".done"},     32'(done),        32'd1);
    chk({e.tag, ".stalls"},   32'(n),           32'(e.stalls));
    chk({e.tag, ".rd_valid"}, 32'(rd_valid[d]), 32'(e.valid));
    chk({e.tag, ".err"},      32'(err[d]),      32'(e.err));
    chk({e.tag, ".rd_data"},  rd_data[d],       e.data);
  endtask

  // Presents one request at a negedge, counts stall cycles until DONE, checks
  // the completion, and returns at the negedge of the following IDLE cycle.
  // With hold set the request stays asserted through DONE.
  task automatic applyStimulus(input int d, input logic rd, input logic wr,
                               input logic [8:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic exp_err,
                               input logic [31:0] load_val, input string tag,
                               input bit hold = 1'b0);
    exp_t e;
    int   n;
    bit   done;
    e.valid  = rd && !wr && !exp_err;
    e.err    = exp_err;
    e.data   = exp_err ? 32'd0 : (e.valid ? load_val : last_rd[d]);
    e.stalls = waits[d] + 1;
    e.tag    = tag;
    sb.push_back(e);
    last_rd[d] = e.data;

    req_rd[d]    = rd;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_f3[d]    = f3;
    #1;
    chk({tag, ".idle_valid"}, 32'(rd_valid[d]), 32'd0);
    chk({tag, ".idle_err"},   32'(err[d]),      32'd0);
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!stall[d]) begin
        done = 1'b1;
        break;
      end
      n++;
      @(negedge clk);
      #1;
    end
    checkOutput(d, n, done);
    if (!hold) clearReq(d);
    @(negedge clk);
  endtask

  // Directed sequence.
  initial begin
    for (int d = 0; d < 3; d++) begin
      clearReq(d);
      reset[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset%0d.stall", d),    32'(stall[d]),    32'd0);
      chk($sformatf("reset%0d.rd_valid", d), 32'(rd_valid[d]), 32'd0);
      chk($sformatf("reset%0d.err", d),      32'(err[d]),      32'd0);
      chk($sformatf("reset%0d.rd_data", d),  rd_data[d],       32'd0);
      chk($sformatf("reset%0d.perf", d),
          perf_loads[d] | perf_stores[d] | perf_stalls[d], 32'd0);
      reset[d] = 1'b0;
    end
    @(negedge clk);

    $display("[TB] WAIT_CYCLES=2: word, sub-word and error accesses");
    applyStimulus(0, 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 32'd0,        "w2_sw_10");
    applyStimulus(0, 1, 0, 9'h010, 32'd0,        3'b010, 0, 32'hDEADBEEF, "w2_lw_10");
    applyStimulus(0, 1, 0, 9'h013, 32'd0,        3'b000, 0, 32'hFFFFFFDE, "w2_lb_13");
    applyStimulus(0, 1, 0, 9'h013, 32'd0,        3'b100, 0, 32'h000000DE, "w2_lbu_13");
    applyStimulus(0, 1, 0, 9'h012, 32'd0,        3'b101, 0, 32'h0000DEAD, "w2_lhu_12");
    applyStimulus(0, 1, 0, 9'h010, 32'd0,        3'b001, 0, 32'hFFFFBEEF, "w2_lh_10");
    applyStimulus(0, 0, 1, 9'h020, 32'h00000000, 3'b010, 0, 32'd0,        "w2_sw_20");
    applyStimulus(0, 0, 1, 9'h020, 32'hFFFF1234, 3'b001, 0, 32'd0,        "w2_sh_20");
    applyStimulus(0, 1, 0, 9'h020, 32'd0,        3'b010, 0, 32'h00001234, "w2_lw_20");
    applyStimulus(0, 0, 1, 9'h023, 32'h000000A5, 3'b000, 0, 32'd0,        "w2_sb_23");
    applyStimulus(0, 1, 0, 9'h020, 32'd0,        3'b010, 0, 32'hA5001234, "w2_lw_20b");
    applyStimulus(0, 1, 0, 9'h021, 32'd0,        3'b001, 1, 32'd0,        "w2_lh_21_err");

    // Request held through DONE must not be taken again.
    applyStimulus(0, 1, 0, 9'h010, 32'd0, 3'b010, 0, 32'hDEADBEEF, "w2_lw_hold", 1'b1);
    clearReq(0);
    #1;
    chk("w2_hold.no_reaccept", 32'(stall[0]), 32'd0);
    @(negedge clk);

    $display("[TB] WAIT_CYCLES=2: reset during WAIT aborts a store");
    applyStimulus(0, 0, 1, 9'h040, 32'h11111111, 3'b010, 0, 32'd0,        "w2_sw_40");
    applyStimulus(0, 1, 0, 9'h010, 32'd0,        3'b010, 0, 32'hDEADBEEF, "w2_lw_10b");
    req_wr[0]    = 1'b1;
    req_addr[0]  = 9'h040;
    req_wdata[0] = 32'hAAAAAAAA;
    req_f3[0]    = 3'b010;
    @(negedge clk);
    @(negedge clk);
    reset[0] = 1'b1;
    clearReq(0);
    #1;
    chk("abort.stall_in_wait", 32'(stall[0]), 32'd1);
    @(negedge clk);
    #1;
    chk("abort.stall",    32'(stall[0]),    32'd0);
    chk("abort.rd_valid", 32'(rd_valid[0]), 32'd0);
    chk("abort.err",      32'(err[0]),      32'd0);
    chk("abort.rd_data",  rd_data[0],       32'd0);
    reset[0]   = 1'b0;
    last_rd[0] = 32'd0;
    @(negedge clk);
    #1;
    chk("abort.idle_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 9'h040, 32'd0, 3'b010, 0, 32'h11111111, "w2_lw_40");

    $display("[TB] WAIT_CYCLES=0: back-to-back accesses and rejected requests");
    applyStimulus(1, 0, 1, 9'h004, 32'h00005A5A, 3'b010, 0, 32'd0,        "w0_sw_04");
    applyStimulus(1, 0, 1, 9'h008, 32'hCAFEF00D, 3'b010, 0, 32'd0,        "w0_sw_08");
    applyStimulus(1, 1, 0, 9'h004, 32'd0,        3'b010, 0, 32'h00005A5A, "w0_lw_04");
    applyStimulus(1, 1, 0, 9'h008, 32'd0,        3'b010, 0, 32'hCAFEF00D, "w0_lw_08");
    applyStimulus(1, 1, 0, 9'h00A, 32'd0,        3'b000, 0, 32'hFFFFFFFE, "w0_lb_0a");
    applyStimulus(1, 1, 0, 9'h008, 32'd0,        3'b011, 1, 32'd0,        "w0_f3_011_err");
    applyStimulus(1, 0, 1, 9'h008, 32'hFFFFFFFF, 3'b100, 1, 32'd0,        "w0_st_f3_100_err");
    applyStimulus(1, 1, 1, 9'h008, 32'h00000000, 3'b010, 1, 32'd0,        "w0_rdwr_err");
    applyStimulus(1, 0, 1, 9'h00A, 32'h00000000, 3'b010, 1, 32'd0,        "w0_sw_misalign_err");
    applyStimulus(1, 1, 0, 9'h008, 32'd0,        3'b010, 0, 32'hCAFEF00D, "w0_lw_08b");

    $display("[TB] WAIT_CYCLES=1: performance counters");
    applyStimulus(2, 0, 1, 9'h000, 32'h00000001, 3'b010, 0, 32'd0,        "w1_sw_00");
    applyStimulus(2, 0, 1, 9'h004, 32'h00000082, 3'b010, 0, 32'd0,        "w1_sw_04");
    applyStimulus(2, 1, 0, 9'h000, 32'd0,        3'b010, 0, 32'h00000001, "w1_lw_00");
    applyStimulus(2, 1, 0, 9'h004, 32'd0,        3'b010, 0, 32'h00000082, "w1_lw_04");
    applyStimulus(2, 1, 0, 9'h004, 32'd0,        3'b000, 0, 32'hFFFFFF82, "w1_lb_04");
    #1;
`ifdef DMEM_PERF_EN
    chk("w1.perf_loads",  perf_loads[2],  32'd3);
    chk("w1.perf_stores", perf_stores[2], 32'd2);
    chk("w1.perf_stalls", perf_stalls[2], 32'd10);
`else
    chk("w1.perf_loads",  perf_loads[2],  32'd0);
    chk("w1.perf_stores", perf_stores[2], 32'd0);
    chk("w1.perf_stalls", perf_stalls[2], 32'd0);
`endif
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. Accepts one load or store request from the MEM stage, models a configurable wait-state latency, and performs RISC-V sub-word access (byte/half/word, signed/unsigned) on an internal byte-addressed store. It back-pressures the pipeline with a stall line until the access completes. It sits on the far side of the datapath's `wr`/`reade`/`addr`/`wr_data`/`funct3` request lines and supplies the returned load data.

## Interface
- `DM_ADDRESS`, 9: byte-address width; storage is 2^(DM_ADDRESS-2) 32-bit words.
- `DATA_W`, 32: data width (only 32 supported).
- `WAIT_CYCLES`, 2: extra busy cycles per access, range 0..15.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_rd` in 1: load request.
- `req_wr` in 1: store request.
- `req_addr` in DM_ADDRESS: byte address.
- `req_wdata` in DATA_W: store data; the low bytes are used for SB/SH.
- `req_funct3` in 3: access size/sign, RISC-V encoding.
- `stall` out 1: pipeline hold request.
- `rd_data` out DATA_W: load result, extended to 32 bits.
- `rd_valid` out 1: one-cycle pulse when a load completes.
- `err` out 1: one-cycle pulse when a request is rejected.
- `perf_loads`, `perf_stores`, `perf_stalls` out 32 each: performance counters (see Configuration).

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE**
  - If `req_rd|req_wr`, latch the op, address, wdata and funct3.
  - `stall` is combinationally high in this cycle.
  - Next state is WAIT if `WAIT_CYCLES>0` (counter loaded with `WAIT_CYCLES`), otherwise DONE.
- **WAIT**
  - `stall`=1; the counter decrements each cycle.
  - At counter==1, go to DONE.
- **DONE**
  - Access executes on the entry edge, so its results are visible during DONE.
  - `stall`=0, and inputs are ignored in this state, so the still-present request is not re-accepted.
  - Always go to IDLE next.
- **Loads** (funct3): 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
  - Bytes are selected by `addr[1:0]`, little-endian.
- **Stores** (funct3): 000 SB, 001 SH, 010 SW, with byte enables derived from `addr[1:0]`.
- **Error conditions**, checked on the latched request:
  - halfword access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - illegal funct3 (011, 110, 111, or any store funct3 ≥100);
  - `req_rd` and `req_wr` both high.
- **On error**
  - No memory write occurs and `rd_valid` stays 0.
  - `err` pulses in DONE and `rd_data` is driven to 0.
- `rd_data` holds the last completed load value until the next load or error.

## Timing
- Pipeline-visible stall is `WAIT_CYCLES+1` cycles per request; total occupancy is `WAIT_CYCLES+2` cycles.
- A back-to-back request is accepted in the IDLE cycle immediately after DONE; there is no idle gap beyond that.
- A store is visible to a load accepted in the next IDLE.
- Reset values: state IDLE, counter 0, `stall`=0, `rd_data`=0, `rd_valid`=0, `err`=0, counters 0.
- Storage contents are not affected by reset; simulation initializes them to 0.
- Reset asserted mid-WAIT aborts the access: no write occurs, no pulse is produced, and `stall` drops in the cycle after the reset edge. The request is not replayed.
- `stall` in IDLE depends combinationally on `req_rd|req_wr`. There is no combinational path from `req_wdata`/`req_addr` to any output.

## Configuration
- `DMEM_PERF_EN` defined:
  - `perf_loads` increments on each successful load in DONE.
  - `perf_stores` increments on each successful store in DONE.
  - `perf_stalls` increments on every cycle `stall`=1.
  - All counters wrap at 2^32 and clear on reset.
- `DMEM_PERF_EN` undefined: the three counter outputs are tied to 0 and no counter logic is built.

## Structure
- Package `dmem_pkg` holds:
  - the `dmem_state_e` enum (IDLE/WAIT/DONE);
  - localparams for the funct3 codes (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the latched-request struct `dmem_req_t` (op, addr, wdata, funct3).
- Sub-module `dmem_lane_align` (combinational) takes funct3, `addr[1:0]`, wdata and the read word. It produces:
  - byte enables;
  - lane-shifted write data;
  - extended load data;
  - the misalign/illegal flag.
- The top level holds the FSM, wait counter, storage array, output registers and the optional counters.

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF @0x010, then LW @0x010 → `stall` high 3 cycles per request, `rd_valid` pulse, `rd_data`=0xDEADBEEF.
- After the above: LB @0x013 → 0xFFFFFFDE; LBU @0x013 → 0x000000DE; LHU @0x012 → 0x0000DEAD.
- SH 0x1234 @0x020 over a word of 0; LW @0x020 → 0x00001234. LH @0x021 → `err` pulse, `rd_data`=0, no `rd_valid`.
- WAIT_CYCLES=0: back-to-back LW requests → `stall` 1 cycle each, DONE alternates with IDLE, one `rd_valid` per request.
- SW 0xAAAAAAAA @0x040 with reset asserted on the 2nd WAIT cycle, then LW @0x040 → 0 (store aborted), `stall`=0 right after reset.
- With `DMEM_PERF_EN`: 3 loads + 2 stores at WAIT_CYCLES=1 → `perf_loads`=3, `perf_stores`=2, `perf_stalls`=10.
